// File: rtl/bpsk_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bpsk_pkg
// Purpose  : Constants shared by the BPSK modulator/demodulator pair:
//            frame geometry, FSM state encoding and symbol values.
// Revision : 1.0 - initial release
// ============================================================================
package bpsk_pkg;

  // Frame geometry, common to modulator and demodulator
  localparam int DATA_W      = 16;
  localparam int ON_LEN      = 60;
  localparam int OFF_LEN     = 10;
  localparam int GAP_TIMEOUT = 40;
  localparam int ACC_W       = 9;

  // Receiver FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Channel symbol values (2-bit two's complement)
  typedef logic signed [1:0] sym_t;
  localparam sym_t SYM_POS  = 2'sb01;
  localparam sym_t SYM_NEG  = 2'sb11;
  localparam sym_t SYM_ZERO = 2'sb00;

endpackage
`default_nettype wire

// File: rtl/bpsk_demodulator_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bpsk_demodulator_if
// Purpose  : Symbol-in / word-out bundle of the BPSK demodulator.
//            master = channel/controller side, slave = demodulator.
// Revision : 1.0 - initial release
// ============================================================================
interface bpsk_demodulator_if #(
  parameter int DATA_W = bpsk_pkg::DATA_W
);
  logic                    demod_en;
  logic signed [1:0]       symbol_in;
  logic [DATA_W-1:0]       data_out;
  logic                    data_valid;
  logic                    frame_err;
  logic                    busy;

  modport master (
    output demod_en, symbol_in,
    input  data_out, data_valid, frame_err, busy
  );

  modport slave (
    input  demod_en, symbol_in,
    output data_out, data_valid, frame_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/bpsk_demodulator_integrator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bpsk_integrator
// Purpose  : Integrate-and-dump for one BPSK burst. Loads the first sample,
//            accumulates the rest, flags the edge that consumes sample ON_LEN
//            and gives the sign decision (negative sum -> 1) for that edge.
// Revision : 1.0 - initial release
// ============================================================================
module bpsk_integrator #(
  parameter int ON_LEN = bpsk_pkg::ON_LEN,
  parameter int ACC_W  = bpsk_pkg::ACC_W
) (
  input  wire logic              clk,
  input  wire logic              reset,     // asynchronous, active low
  input  wire logic              i_clear,
  input  wire logic              i_load,
  input  wire logic              i_acc_en,
  input  wire logic signed [1:0] i_sym,
  output logic                   o_done,
  output logic                   o_bit
);
  localparam int CNT_W = $clog2(ON_LEN + 1);

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] w_sym_ext;
  logic signed [ACC_W-1:0] w_acc_sum;

  // Sign-extend the sample and form the running sum including this sample
  always_comb begin
    w_sym_ext = {{(ACC_W-2){i_sym[1]}}, i_sym};
    w_acc_sum = r_acc + w_sym_ext;
    o_done    = i_acc_en && (r_cnt == CNT_W'(ON_LEN - 1));
    o_bit     = w_acc_sum[ACC_W-1];
  end

  // Accumulator and sample counter; dump (clear) once the window closes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= w_sym_ext;
      r_cnt <= CNT_W'(1);
    end else if (i_acc_en) begin
      if (o_done) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_acc_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/bpsk_demodulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bpsk_demodulator
// Purpose  : BPSK receiver. Detects 60-sample bursts, integrates each one,
//            collects 16 decisions LSB first and strobes the recovered word.
//            Aborts a frame with frame_err if a gap lasts GAP_TIMEOUT zeros.
// Revision : 1.0 - initial release
// ============================================================================
module bpsk_demodulator #(
  parameter int DATA_W      = bpsk_pkg::DATA_W,
  parameter int ON_LEN      = bpsk_pkg::ON_LEN,
  parameter int GAP_TIMEOUT = bpsk_pkg::GAP_TIMEOUT,
  parameter int ACC_W       = bpsk_pkg::ACC_W
) (
  input  wire logic          clk,
  input  wire logic          reset,   // asynchronous, active low
  bpsk_demodulator_if.slave  bus
);
  import bpsk_pkg::*;

  localparam int BIDX_W = $clog2(DATA_W);
  localparam int GAP_W  = $clog2(GAP_TIMEOUT + 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [BIDX_W-1:0] r_bit_idx;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [DATA_W-2:0] r_shift;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid;
  logic              r_err;
  logic              r_busy;

  logic w_sym_nz;
  logic w_last_bit;
  logic w_timeout;
  logic w_clear;
  logic w_load;
  logic w_acc_en;
  logic w_done;
  logic w_bit;

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_valid;
  assign bus.frame_err  = r_err;
  assign bus.busy       = r_busy;

  // Integrator control: a non-zero sample in IDLE/GAP opens a new burst
  always_comb begin
    w_sym_nz   = (bus.symbol_in != SYM_ZERO);
    w_last_bit = (r_bit_idx == BIDX_W'(DATA_W - 1));
    w_timeout  = (r_gap_cnt == GAP_W'(GAP_TIMEOUT - 1));
    w_clear    = !bus.demod_en;
    w_load     = bus.demod_en && w_sym_nz && (r_state == ST_IDLE || r_state == ST_GAP);
    w_acc_en   = bus.demod_en && (r_state == ST_ON);
  end

  bpsk_integrator #(
    .ON_LEN (ON_LEN),
    .ACC_W  (ACC_W)
  ) u_integrator (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_load   (w_load),
    .i_acc_en (w_acc_en),
    .i_sym    (bus.symbol_in),
    .o_done   (w_done),
    .o_bit    (w_bit)
  );

  // Next-state decode; a low demod_en overrides every other event
  always_comb begin
    w_state_nxt = r_state;
    if (!bus.demod_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_sym_nz) w_state_nxt = ST_ON;
        ST_ON:   if (w_done)   w_state_nxt = w_last_bit ? ST_IDLE : ST_GAP;
        ST_GAP: begin
          if (w_sym_nz)       w_state_nxt = ST_ON;
          else if (w_timeout) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, bit collection, gap timer and output strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_bit_idx  <= '0;
      r_gap_cnt  <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_ON) || (w_state_nxt == ST_GAP);
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (!bus.demod_en) begin
        r_bit_idx <= '0;
        r_gap_cnt <= '0;
        r_shift   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_bit_idx <= '0;
            r_gap_cnt <= '0;
          end
          ST_ON: begin
            if (w_done) begin
              if (w_last_bit) begin
                // Bits enter the shift register at the top and walk down,
                // so bit 0 sits at index 0 when the last bit arrives.
                r_data_out <= {w_bit, r_shift};
                r_valid    <= 1'b1;
                r_shift    <= '0;
                r_bit_idx  <= '0;
              end else begin
                r_shift   <= {w_bit, r_shift[DATA_W-2:1]};
                r_bit_idx <= r_bit_idx + BIDX_W'(1);
                r_gap_cnt <= '0;
              end
            end
          end
          ST_GAP: begin
            if (w_sym_nz) begin
              r_gap_cnt <= '0;
            end else if (w_timeout) begin
              r_err     <= 1'b1;
              r_shift   <= '0;
              r_bit_idx <= '0;
              r_gap_cnt <= '0;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
          default: begin
            r_bit_idx <= '0;
            r_gap_cnt <= '0;
            r_shift   <= '0;
          end
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bpsk_demodulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bpsk_demodulator
// Purpose  : Directed, table-driven bench for bpsk_demodulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpsk_demodulator;
  import bpsk_pkg::*;

  typedef struct {
    logic [15:0] word;
    int          zeros;   // 1: samples 21..40 of every burst forced to 0
    int          sbit;    // bit index with a special burst, -1 none
    int          skind;   // 1: 35x(-1) then 25x(+1); 2: 30x(+1) then 30x(-1)
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_err = 0;
  int   n_both = 0;
  vec_t tbl [8];

  bpsk_demodulator_if bus ();

  bpsk_demodulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (bus.data_valid) n_valid++;
    if (bus.frame_err) n_err++;
    if (bus.data_valid && bus.frame_err) n_both++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic signed [1:0] s);
    bus.symbol_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) drive(SYM_ZERO);
  endtask

  task automatic burst(input logic b, input int zeros, input int kind, input int nsamp);
    for (int s = 0; s < nsamp; s++) begin
      logic signed [1:0] v;
      v = b ? SYM_NEG : SYM_POS;
      if (kind == 1)                            v = (s < 35) ? SYM_NEG : SYM_POS;
      else if (kind == 2)                       v = (s < 30) ? SYM_POS : SYM_NEG;
      else if (zeros != 0 && s >= 20 && s < 40) v = SYM_ZERO;
      drive(v);
    end
  endtask

  // Bits 0..nbits-1, 10-zero gap between bursts, none after the last
  task automatic send_bits(input logic [15:0] w, input int nbits, input int zeros,
                           input int sbit, input int skind);
    for (int i = 0; i < nbits; i++) begin
      burst(w[i], zeros, (i == sbit) ? skind : 0, ON_LEN);
      if (i != nbits - 1) gap(OFF_LEN);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    send_bits(v.word, 16, v.zeros, v.sbit, v.skind);
    chk({name, " valid after last sample"}, 32'(bus.data_valid), 32'd1);
    chk({name, " data_out"}, 32'(bus.data_out), 32'(v.exp));
    chk({name, " busy after frame"}, 32'(bus.busy), 32'd0);
    drive(SYM_ZERO);
    chk({name, " valid one cycle"}, 32'(bus.data_valid), 32'd0);
    chk({name, " valid pulse count"}, 32'(n_valid - v0), 32'd1);
    chk({name, " frame_err count"}, 32'(n_err - e0), 32'd0);
  endtask

  initial begin
    int v0;
    int e0;
    tbl[0] = '{16'hA5C3, 0, -1, 0, 16'hA5C3};
    tbl[1] = '{16'h0000, 0, -1, 0, 16'h0000};
    tbl[2] = '{16'hFFFF, 0, -1, 0, 16'hFFFF};
    tbl[3] = '{16'h0001, 0,  0, 2, 16'h0000};
    tbl[4] = '{16'h1234, 1,  7, 1, 16'h12B4};
    tbl[5] = '{16'h00FF, 0, -1, 0, 16'h00FF};
    tbl[6] = '{16'hBEEF, 0, -1, 0, 16'hBEEF};
    tbl[7] = '{16'h5555, 0, -1, 0, 16'h5555};

    bus.demod_en  = 1'b0;
    bus.symbol_in = SYM_ZERO;
    repeat (3) @(posedge clk);
    #1;
    chk("reset data_out", 32'(bus.data_out), 32'd0);
    chk("reset data_valid", 32'(bus.data_valid), 32'd0);
    chk("reset frame_err", 32'(bus.frame_err), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    bus.demod_en = 1'b1;
    gap(3);
    chk("idle on zeros busy", 32'(bus.busy), 32'd0);

    // Table frames, 1 idle cycle between consecutive frames
    for (int k = 0; k < 5; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

    // Gap timeout after bit 5; data_out keeps 12B4
    v0 = n_valid;
    e0 = n_err;
    send_bits(16'h002A, 6, 0, -1, 0);
    chk("abort busy in gap", 32'(bus.busy), 32'd1);
    gap(GAP_TIMEOUT - 1);
    chk("abort no err at 39", 32'(bus.frame_err), 32'd0);
    drive(SYM_ZERO);
    chk("abort err at 40", 32'(bus.frame_err), 32'd1);
    chk("abort busy idle", 32'(bus.busy), 32'd0);
    chk("abort data_out kept", 32'(bus.data_out), 32'h12B4);
    drive(SYM_ZERO);
    chk("abort err one cycle", 32'(bus.frame_err), 32'd0);
    chk("abort err count", 32'(n_err - e0), 32'd1);
    chk("abort no valid", 32'(n_valid - v0), 32'd0);
    run_vec(tbl[5], "after abort 00FF");

    // Asynchronous reset in the middle of bit 9's burst
    send_bits(16'hFFFF, 9, 0, -1, 0);
    gap(OFF_LEN);
    burst(1'b0, 0, 0, 30);
    chk("mid burst busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async reset data_out", 32'(bus.data_out), 32'd0);
    chk("async reset busy", 32'(bus.busy), 32'd0);
    chk("async reset valid", 32'(bus.data_valid), 32'd0);
    chk("async reset err", 32'(bus.frame_err), 32'd0);
    bus.symbol_in = SYM_ZERO;
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    run_vec(tbl[6], "after reset BEEF");

    // demod_en dropped in the gap after bit 3
    v0 = n_valid;
    send_bits(16'hFFFF, 4, 0, -1, 0);
    gap(5);
    chk("en drop busy before", 32'(bus.busy), 32'd1);
    bus.demod_en = 1'b0;
    drive(SYM_ZERO);
    chk("en drop busy", 32'(bus.busy), 32'd0);
    drive(SYM_POS);
    chk("disabled stays idle", 32'(bus.busy), 32'd0);
    chk("en drop no pulse", 32'(n_valid - v0), 32'd0);
    bus.demod_en = 1'b1;
    drive(SYM_ZERO);
    run_vec(tbl[7], "after en drop 5555");

    // demod_en falls on the edge of bit 15's final sample
    v0 = n_valid;
    send_bits(16'h0F0F, 15, 0, -1, 0);
    gap(OFF_LEN);
    burst(1'b1, 0, 0, ON_LEN - 1);
    bus.demod_en = 1'b0;
    drive(SYM_NEG);
    chk("en vs decide valid", 32'(bus.data_valid), 32'd0);
    chk("en vs decide data_out", 32'(bus.data_out), 32'h5555);
    drive(SYM_ZERO);
    chk("en vs decide count", 32'(n_valid - v0), 32'd0);
    bus.demod_en = 1'b1;
    drive(SYM_ZERO);

    chk("valid and err together", 32'(n_both), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
